// File: rtl/reg_file_pkg.sv
// Shared constants for the 2-write / 2-read register file.
// Default widths and the entry-count derivation.
package reg_file_pkg;

    localparam int unsigned DWIDTH_DEF = 8;
    localparam int unsigned AWIDTH_DEF = 3;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/reg_file_rport.sv
// Registered read port: DEPTH:1 mux, optional write bypass, rdata/rvalid flops.
// REG_FILE_BYPASS_EN selects write-first; otherwise read-first.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    localparam int unsigned DEPTH = depth_of(AWIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEPTH-1:0][DWIDTH-1:0] mem_i,
    input  logic                         wen_a_i,
    input  logic [AWIDTH-1:0]            waddr_a_i,
    input  logic [DWIDTH-1:0]            wdata_a_i,
    input  logic                         wen_b_i,
    input  logic [AWIDTH-1:0]            waddr_b_i,
    input  logic [DWIDTH-1:0]            wdata_b_i,
    input  logic                         ren_i,
    input  logic [AWIDTH-1:0]            raddr_i,
    output logic [DWIDTH-1:0]            rdata_o,
    output logic                         rvalid_o
);

    logic [DWIDTH-1:0] rdata_d, rdata_q;
    logic              rvalid_q;

`ifdef REG_FILE_BYPASS_EN
    // Port A is checked last so it wins when both writes hit this address.
    always_comb begin
        rdata_d = mem_i[raddr_i];
        if (wen_b_i && (waddr_b_i == raddr_i)) rdata_d = wdata_b_i;
        if (wen_a_i && (waddr_a_i == raddr_i)) rdata_d = wdata_a_i;
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wen_a_i, waddr_a_i, wdata_a_i,
                         wen_b_i, waddr_b_i, wdata_b_i};

    always_comb begin
        rdata_d = mem_i[raddr_i];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ren_i;
            if (ren_i) rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    // A pulse already in flight is squashed by a reset in the same cycle.
    assign rvalid_o = rvalid_q & ~rst;

endmodule

// File: rtl/reg_file_2w2r_p.sv
// 2-write / 2-read register file; port A wins same-address write collisions.
// Read-during-write policy selected by REG_FILE_BYPASS_EN.
module reg_file_2w2r_p
    import reg_file_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_a,
    input  logic [AWIDTH-1:0] waddr_a,
    input  logic [DWIDTH-1:0] wdata_a,
    input  logic              wen_b,
    input  logic [AWIDTH-1:0] waddr_b,
    input  logic [DWIDTH-1:0] wdata_b,
    input  logic              ren_a,
    input  logic [AWIDTH-1:0] raddr_a,
    input  logic              ren_b,
    input  logic [AWIDTH-1:0] raddr_b,
    output logic [DWIDTH-1:0] rdata_a,
    output logic [DWIDTH-1:0] rdata_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic              wcollide
);

    localparam int unsigned DEPTH = depth_of(AWIDTH);

    logic [DEPTH-1:0][DWIDTH-1:0] mem_d, mem_q;
    logic                         wcollide_d, wcollide_q;

    // B is applied first so A overwrites it on a collision.
    always_comb begin
        mem_d = mem_q;
        if (wen_b) mem_d[waddr_b] = wdata_b;
        if (wen_a) mem_d[waddr_a] = wdata_a;
    end

    assign wcollide_d = wen_a & wen_b & (waddr_a == waddr_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '0;
            wcollide_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wcollide_q <= wcollide_d;
        end
    end

    assign wcollide = wcollide_q;

    reg_file_rport #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_rport_a (
        .clk       (clk),
        .rst       (rst),
        .mem_i     (mem_q),
        .wen_a_i   (wen_a),
        .waddr_a_i (waddr_a),
        .wdata_a_i (wdata_a),
        .wen_b_i   (wen_b),
        .waddr_b_i (waddr_b),
        .wdata_b_i (wdata_b),
        .ren_i     (ren_a),
        .raddr_i   (raddr_a),
        .rdata_o   (rdata_a),
        .rvalid_o  (rvalid_a)
    );

    reg_file_rport #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_rport_b (
        .clk       (clk),
        .rst       (rst),
        .mem_i     (mem_q),
        .wen_a_i   (wen_a),
        .waddr_a_i (waddr_a),
        .wdata_a_i (wdata_a),
        .wen_b_i   (wen_b),
        .waddr_b_i (waddr_b),
        .wdata_b_i (wdata_b),
        .ren_i     (ren_b),
        .raddr_i   (raddr_b),
        .rdata_o   (rdata_b),
        .rvalid_o  (rvalid_b)
    );

endmodule
